// File: rtl/mdio_regs_arbiter.sv
// mdio_regs_arbiter
// Two-master, one-slave Wishbone arbiter in front of the PHY management
// register block. Master 0 is the MDIO serial-frame bridge, master 1 the
// local management/debug master.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   m0_* / m1_*               Wishbone master ports (cyc/stb/we/addr/data in,
//                             ack/err/data_read out)
//   s_*                       Wishbone port to the register block
//   grant                     one-hot owner (bit0 = m0, bit1 = m1), 00 idle
//   timeout_event             one-cycle pulse when the watchdog aborts
//
// Ownership is registered and held for the whole cyc, with round-robin
// selection on contention. A watchdog terminates strobes the slave never
// answers by returning err to the owner.
module mdio_regs_arbiter #(
    parameter int unsigned TIMEOUT       = 16,
    parameter int unsigned TIMEOUT_WIDTH = 5
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        m0_cyc,
    input  logic        m0_stb,
    input  logic        m0_we,
    input  logic [4:0]  m0_addr,
    input  logic [15:0] m0_data_write,
    output logic        m0_ack,
    output logic        m0_err,
    output logic [15:0] m0_data_read,

    input  logic        m1_cyc,
    input  logic        m1_stb,
    input  logic        m1_we,
    input  logic [4:0]  m1_addr,
    input  logic [15:0] m1_data_write,
    output logic        m1_ack,
    output logic        m1_err,
    output logic [15:0] m1_data_read,

    output logic        s_cyc,
    output logic        s_stb,
    output logic        s_we,
    output logic [4:0]  s_addr,
    output logic [15:0] s_data_write,
    input  logic        s_ack,
    input  logic        s_err,
    input  logic [15:0] s_data_read,

    output logic [1:0]  grant,
    output logic        timeout_event
);

    // State encoding doubles as the one-hot grant vector.
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        OWN0 = 2'b01,
        OWN1 = 2'b10
    } state_t;

    localparam logic [TIMEOUT_WIDTH-1:0] TIMEOUT_CNT = TIMEOUT_WIDTH'(TIMEOUT);

    state_t                   state_reg, state_next;
    logic                     last_owner_reg, last_owner_next;
    logic [TIMEOUT_WIDTH-1:0] count_reg, count_next;

    logic        owner_cyc;
    logic        owner_stb;
    logic        abort;
    logic [1:0]  ack_vec;
    logic [1:0]  err_vec;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= IDLE;
            last_owner_reg <= 1'b1;   // m0 wins the first contention
            count_reg      <= '0;
        end else begin
            state_reg      <= state_next;
            last_owner_reg <= last_owner_next;
            count_reg      <= count_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state: round-robin on contention, handover without an idle
    // cycle when the other master is already waiting.
    // ------------------------------------------------------------------
    always_comb begin
        state_next      = state_reg;
        last_owner_next = last_owner_reg;
        case (state_reg)
            IDLE: begin
                if (m0_cyc && m1_cyc) begin
                    state_next = last_owner_reg ? OWN0 : OWN1;
                end else if (m0_cyc) begin
                    state_next = OWN0;
                end else if (m1_cyc) begin
                    state_next = OWN1;
                end
            end
            OWN0: begin
                if (!m0_cyc) begin
                    state_next = m1_cyc ? OWN1 : IDLE;
                end
            end
            OWN1: begin
                if (!m1_cyc) begin
                    state_next = m0_cyc ? OWN0 : IDLE;
                end
            end
            default: state_next = IDLE;
        endcase

        if (state_next == OWN0) begin
            last_owner_next = 1'b0;
        end else if (state_next == OWN1) begin
            last_owner_next = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Request routing from the registered owner
    // ------------------------------------------------------------------
    always_comb begin
        owner_cyc    = 1'b0;
        owner_stb    = 1'b0;
        s_we         = 1'b0;
        s_addr       = '0;
        s_data_write = '0;
        case (state_reg)
            OWN0: begin
                owner_cyc    = m0_cyc;
                owner_stb    = m0_stb;
                s_we         = m0_we;
                s_addr       = m0_addr;
                s_data_write = m0_data_write;
            end
            OWN1: begin
                owner_cyc    = m1_cyc;
                owner_stb    = m1_stb;
                s_we         = m1_we;
                s_addr       = m1_addr;
                s_data_write = m1_data_write;
            end
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // Watchdog. The count holds the number of cycles the current strobe
    // has already waited; reaching TIMEOUT makes this the abort cycle.
    // The strobe is withheld from the slave in that cycle so a late
    // slave cannot complete an access the master has already seen fail.
    // ------------------------------------------------------------------
    always_comb begin
        abort = 1'b0;
        if (TIMEOUT != 0) begin
            abort = owner_stb && (count_reg == TIMEOUT_CNT);
        end
    end

    always_comb begin
        count_next = count_reg + TIMEOUT_WIDTH'(1);
        if (TIMEOUT == 0 || abort || !owner_stb || s_ack || s_err ||
            state_next != state_reg) begin
            count_next = '0;
        end
    end

    assign s_cyc         = owner_cyc & ~abort;
    assign s_stb         = owner_stb & ~abort;
    assign timeout_event = abort;
    assign grant         = state_reg;

    // ------------------------------------------------------------------
    // Termination returns: only the owner ever sees ack/err; an abort
    // turns a coincident slave ack into err.
    // ------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_ret
            assign ack_vec[gi] = s_ack & state_reg[gi] & ~abort;
            assign err_vec[gi] = (s_err | abort) & state_reg[gi];
        end
    endgenerate

    assign m0_ack       = ack_vec[0];
    assign m1_ack       = ack_vec[1];
    assign m0_err       = err_vec[0];
    assign m1_err       = err_vec[1];
    assign m0_data_read = s_data_read;
    assign m1_data_read = s_data_read;

endmodule

// File: tb/tb_mdio_regs_arbiter.sv
// Testbench for mdio_regs_arbiter: a register-block slave model answers one
// cycle after each strobe; expected read data is queued per master when an
// access is driven and compared when that master receives ack. A second
// instance with the watchdog disabled shares the master inputs.
module tb_mdio_regs_arbiter;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // master drive
    logic        mc [2];
    logic        ms [2];
    logic        mw [2];
    logic [4:0]  ma [2];
    logic [15:0] md [2];

    // main DUT outputs
    logic        m0_ack, m0_err, m1_ack, m1_err;
    logic [15:0] m0_data_read, m1_data_read;
    logic        s_cyc, s_stb, s_we;
    logic [4:0]  s_addr;
    logic [15:0] s_data_write;
    logic [15:0] s_data_read;
    logic [1:0]  grant;
    logic        timeout_event;

    // watchdog-disabled DUT outputs
    logic        nw_m0_ack, nw_m0_err, nw_m1_ack, nw_m1_err;
    logic [15:0] nw_m0_data_read, nw_m1_data_read;
    logic        nw_s_cyc, nw_s_stb, nw_s_we;
    logic [4:0]  nw_s_addr;
    logic [15:0] nw_s_data_write;
    logic [1:0]  nw_grant;
    logic        nw_timeout_event;

    // slave model
    logic        sack;
    logic        slave_mute;
    logic        tie0 = 1'b0;
    logic [15:0] tie0_16 = 16'h0000;
    logic [15:0] smem [32];

    always @(posedge clk) begin
        if (rst) begin
            sack <= 1'b0;
        end else begin
            sack <= s_stb & ~sack & ~slave_mute;
            if (s_stb && !sack && s_we && !slave_mute) smem[s_addr] <= s_data_write;
        end
    end
    assign s_data_read = smem[s_addr];

    mdio_regs_arbiter #(.TIMEOUT(4), .TIMEOUT_WIDTH(5)) dut (
        .clk(clk), .rst(rst),
        .m0_cyc(mc[0]), .m0_stb(ms[0]), .m0_we(mw[0]), .m0_addr(ma[0]),
        .m0_data_write(md[0]), .m0_ack(m0_ack), .m0_err(m0_err),
        .m0_data_read(m0_data_read),
        .m1_cyc(mc[1]), .m1_stb(ms[1]), .m1_we(mw[1]), .m1_addr(ma[1]),
        .m1_data_write(md[1]), .m1_ack(m1_ack), .m1_err(m1_err),
        .m1_data_read(m1_data_read),
        .s_cyc(s_cyc), .s_stb(s_stb), .s_we(s_we), .s_addr(s_addr),
        .s_data_write(s_data_write), .s_ack(sack), .s_err(tie0),
        .s_data_read(s_data_read),
        .grant(grant), .timeout_event(timeout_event)
    );

    mdio_regs_arbiter #(.TIMEOUT(0), .TIMEOUT_WIDTH(5)) dut_nw (
        .clk(clk), .rst(rst),
        .m0_cyc(mc[0]), .m0_stb(ms[0]), .m0_we(mw[0]), .m0_addr(ma[0]),
        .m0_data_write(md[0]), .m0_ack(nw_m0_ack), .m0_err(nw_m0_err),
        .m0_data_read(nw_m0_data_read),
        .m1_cyc(mc[1]), .m1_stb(ms[1]), .m1_we(mw[1]), .m1_addr(ma[1]),
        .m1_data_write(md[1]), .m1_ack(nw_m1_ack), .m1_err(nw_m1_err),
        .m1_data_read(nw_m1_data_read),
        .s_cyc(nw_s_cyc), .s_stb(nw_s_stb), .s_we(nw_s_we), .s_addr(nw_s_addr),
        .s_data_write(nw_s_data_write), .s_ack(tie0), .s_err(tie0),
        .s_data_read(tie0_16),
        .grant(nw_grant), .timeout_event(nw_timeout_event)
    );

    // ------------------------------------------------------------------
    // checking and scoreboard
    // ------------------------------------------------------------------
    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    typedef struct {
        bit          we;
        logic [4:0]  addr;
        logic [15:0] data;
    } exp_t;

    exp_t        q0[$];
    exp_t        q1[$];
    logic [15:0] ref_mem [32];
    exp_t        mon_e;

    function automatic logic get_ack(input int m);
        return (m == 0) ? m0_ack : m1_ack;
    endfunction

    function automatic logic get_err(input int m);
        return (m == 0) ? m0_err : m1_err;
    endfunction

    always @(negedge clk) begin
        if (!rst && (m0_ack || m1_ack)) begin
            check("ack_exclusive", 32'(m0_ack & m1_ack), 32'd0);
            if (m0_ack) begin
                check("sb0_nonempty", 32'(q0.size() != 0), 32'd1);
                if (q0.size() != 0) begin
                    mon_e = q0.pop_front();
                    $display("txn m0 %s addr=%0d data=%h", mon_e.we ? "WR" : "RD",
                             mon_e.addr, mon_e.we ? mon_e.data : m0_data_read);
                    if (!mon_e.we) check("m0_rdata", 32'(m0_data_read), 32'(mon_e.data));
                end
            end
            if (m1_ack) begin
                check("sb1_nonempty", 32'(q1.size() != 0), 32'd1);
                if (q1.size() != 0) begin
                    mon_e = q1.pop_front();
                    $display("txn m1 %s addr=%0d data=%h", mon_e.we ? "WR" : "RD",
                             mon_e.addr, mon_e.we ? mon_e.data : m1_data_read);
                    if (!mon_e.we) check("m1_rdata", 32'(m1_data_read), 32'(mon_e.data));
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // stimulus helpers
    // ------------------------------------------------------------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start(input int m, input bit we, input logic [4:0] a,
                         input logic [15:0] d, input bit push);
        exp_t e;
        mc[m] = 1'b1;
        ms[m] = 1'b1;
        mw[m] = we;
        ma[m] = a;
        md[m] = d;
        if (push) begin
            if (we) ref_mem[a] = d;
            e.we   = we;
            e.addr = a;
            e.data = we ? d : ref_mem[a];
            if (m == 0) q0.push_back(e); else q1.push_back(e);
        end
    endtask

    task automatic finish(input int m, input bit drop);
        int n = 0;
        bit seen = 0;
        while (!seen && n < 20) begin
            @(negedge clk);
            n++;
            if (get_ack(m) || get_err(m)) begin
                seen = 1;
                check("other_ack_low", 32'(get_ack(1 - m)), 32'd0);
            end
        end
        check($sformatf("m%0d_terminated", m), 32'(seen), 32'd1);
        @(posedge clk);
        #1;
        ms[m] = 1'b0;
        if (drop) mc[m] = 1'b0;
        @(negedge clk);
        check("ack_single_cycle", 32'(get_ack(m)), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL global_time_limit checks=%0d", checks);
        $fatal(1);
    end

    // ------------------------------------------------------------------
    // main sequence
    // ------------------------------------------------------------------
    initial begin
        int errs;
        int evs;
        for (int i = 0; i < 32; i++) begin
            smem[i]    = 16'hA000 + 16'(i);
            ref_mem[i] = 16'hA000 | 16'(i);
        end
        for (int i = 0; i < 2; i++) begin
            mc[i] = 0; ms[i] = 0; mw[i] = 0; ma[i] = 0; md[i] = 0;
        end
        slave_mute = 0;
        rst = 1;
        repeat (3) tick();
        @(negedge clk);
        check("rst_grant", 32'(grant), 32'd0);
        check("rst_s_cyc", 32'(s_cyc), 32'd0);
        check("rst_s_stb", 32'(s_stb), 32'd0);
        check("rst_acks", 32'({m0_ack, m1_ack, m0_err, m1_err}), 32'd0);
        check("rst_tev", 32'(timeout_event), 32'd0);
        tick();
        rst = 0;
        repeat (2) tick();

        // single master m1 read of addr 1
        start(1, 0, 5'd1, 16'h0, 1);
        @(negedge clk);
        check("single_grant_pre", 32'(grant), 32'd0);
        @(negedge clk);
        check("single_grant", 32'(grant), 32'b10);
        check("single_s_addr", 32'(s_addr), 32'd1);
        check("single_s_cyc", 32'(s_cyc), 32'd1);
        finish(1, 1);
        repeat (2) tick();

        // contention: m0 wins, direct handover to m1
        start(0, 1, 5'd3, 16'h1234, 1);
        start(1, 0, 5'd3, 16'h0, 1);
        @(negedge clk);
        check("cont_grant_pre", 32'(grant), 32'd0);
        @(negedge clk);
        check("cont_grant_m0", 32'(grant), 32'b01);
        finish(0, 1);
        check("handover_prev", 32'(grant), 32'b01);
        @(negedge clk);
        check("handover_m1", 32'(grant), 32'b10);
        finish(1, 1);
        repeat (2) tick();

        // round robin: m0 last -> m1 wins
        start(0, 1, 5'd4, 16'h0044, 1);
        finish(0, 1);
        repeat (2) tick();
        start(0, 0, 5'd4, 16'h0, 1);
        start(1, 0, 5'd3, 16'h0, 1);
        @(negedge clk);
        @(negedge clk);
        check("rr_m1", 32'(grant), 32'b10);
        finish(1, 1);
        finish(0, 1);
        repeat (2) tick();
        // m1 last -> m0 wins
        start(1, 1, 5'd8, 16'h0808, 1);
        finish(1, 1);
        repeat (2) tick();
        start(0, 0, 5'd8, 16'h0, 1);
        start(1, 0, 5'd4, 16'h0, 1);
        @(negedge clk);
        @(negedge clk);
        check("rr_m0", 32'(grant), 32'b01);
        finish(0, 1);
        finish(1, 1);
        repeat (2) tick();

        // grant hold across three strobes within one cyc
        start(0, 1, 5'd5, 16'h0555, 1);
        start(1, 0, 5'd6, 16'h0, 1);
        @(negedge clk);
        @(negedge clk);
        check("hold_grant0", 32'(grant), 32'b01);
        finish(0, 0);
        check("hold_grant1", 32'(grant), 32'b01);
        start(0, 1, 5'd5, 16'h5550, 1);
        finish(0, 0);
        check("hold_grant2", 32'(grant), 32'b01);
        start(0, 0, 5'd5, 16'h0, 1);
        finish(0, 1);
        check("hold_grant3", 32'(grant), 32'b01);
        @(negedge clk);
        check("hold_release", 32'(grant), 32'b10);
        finish(1, 1);
        repeat (2) tick();

        // watchdog with a silent slave
        slave_mute = 1;
        start(0, 0, 5'd7, 16'h0, 0);
        @(negedge clk);
        @(negedge clk);
        check("wd_grant", 32'(grant), 32'b01);
        check("wd_stb0", 32'(s_stb), 32'd1);
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            check($sformatf("wd_wait%0d", k), 32'({m0_err, timeout_event, s_stb}), 32'b001);
        end
        @(negedge clk);
        check("wd_abort_err", 32'(m0_err), 32'd1);
        check("wd_abort_tev", 32'(timeout_event), 32'd1);
        check("wd_abort_stb", 32'(s_stb), 32'd0);
        check("wd_abort_ack", 32'({m0_ack, m1_err}), 32'd0);
        check("wd_abort_grant", 32'(grant), 32'b01);
        @(negedge clk);
        check("wd_after", 32'({m0_err, timeout_event, s_stb}), 32'b001);
        errs = 0;
        evs  = 0;
        repeat (100) begin
            @(negedge clk);
            if (nw_m0_err || nw_m1_err) errs++;
            if (timeout_event) evs++;
        end
        check("nowd_err_count", 32'(errs), 32'd0);
        check("nowd_stb", 32'(nw_s_stb), 32'd1);
        check("wd_event_count", 32'(evs), 32'd20);
        tick();
        mc[0] = 0;
        ms[0] = 0;
        slave_mute = 0;
        repeat (2) tick();

        // reset during an in-flight access
        slave_mute = 1;
        start(0, 0, 5'd2, 16'h0, 0);
        @(negedge clk);
        @(negedge clk);
        check("prerst_grant", 32'(grant), 32'b01);
        tick();
        rst = 1;
        tick();
        @(negedge clk);
        check("midrst_grant", 32'(grant), 32'd0);
        check("midrst_s_cyc", 32'(s_cyc), 32'd0);
        check("midrst_s_stb", 32'(s_stb), 32'd0);
        check("midrst_acks", 32'({m0_ack, m0_err, m1_ack, m1_err}), 32'd0);
        mc[0] = 0;
        ms[0] = 0;
        slave_mute = 0;
        tick();
        rst = 0;
        start(1, 0, 5'd1, 16'h0, 1);
        @(negedge clk);
        @(negedge clk);
        check("postrst_m1", 32'(grant), 32'b10);
        finish(1, 1);
        repeat (2) tick();

        check("sb0_drained", 32'(q0.size()), 32'd0);
        check("sb1_drained", 32'(q1.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
